// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver: time-slices one shared segment bus across
// four common-anode digits, with a blanking gap at the start of every slot and per-frame input snapshots.
module seg_scan_driver #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [3:0] dp_in,
  input  logic [3:0] digit_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  typedef enum logic {BLANK, ON} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       digit, digit_nxt;
  logic             running;
  logic             snap_load;
  logic [6:0]       seg_snap [4];
  logic [3:0]       dp_snap, en_snap;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic [3:0]       an_nxt;
  logic             frame_done_nxt;

  // The first edge after reset holds cnt/digit at 0 so it becomes the snapshot edge of frame 0.
  always_comb begin
    cnt_nxt   = cnt;
    digit_nxt = digit;
    if (running) begin
      if (cnt == CNT_MAX) begin
        cnt_nxt   = '0;
        digit_nxt = digit + 2'd1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  assign snap_load = (cnt_nxt == '0) && (digit_nxt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode the upcoming cnt/digit so they move on the same edge as the counters.
  always_comb begin
    state_nxt      = state;
    an_nxt         = 4'b1111;
    seg_nxt        = 7'h7F;
    dp_nxt         = 1'b1;
    frame_done_nxt = (digit_nxt == 2'd3) && (cnt_nxt == CNT_MAX);
    case (state)
      BLANK:   if (cnt_nxt == BLANK_LIM) state_nxt = ON;
      ON:      if (cnt_nxt == '0)        state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
    if (state_nxt == ON) begin
      an_nxt  = ~({3'b000, en_snap[digit_nxt]} << digit_nxt);
      seg_nxt = seg_snap[digit_nxt];
      dp_nxt  = dp_snap[digit_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      digit      <= 2'd0;
      running    <= 1'b0;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
      for (int i = 0; i < 4; i++) seg_snap[i] <= 7'h7F;
      dp_snap    <= 4'hF;
      en_snap    <= 4'h0;
    end else begin
      cnt        <= cnt_nxt;
      digit      <= digit_nxt;
      running    <= 1'b1;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= frame_done_nxt;
      if (snap_load) begin
        seg_snap[0] <= seg0;
        seg_snap[1] <= seg1;
        seg_snap[2] <= seg2;
        seg_snap[3] <= seg3;
        dp_snap     <= dp_in;
        en_snap     <= digit_en;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (CLK_DIV=8, BLANK_CYCLES=2): directed scenarios
// followed by random frames, all compared against a frame-timeline reference model.
module tb_seg_scan_driver;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg0, seg1, seg2, seg3;
  logic [3:0] dp_in, digit_en;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  int compCount = 0;
  int errCount  = 0;

  // Model: edges since reset release, plus the inputs captured at each frame start.
  int         t = 0;
  logic [6:0] mSeg [4];
  logic [3:0] mDp, mEn;

  seg_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .dp_in(dp_in), .digit_en(digit_en),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s at t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // One clock: drive rst (and optionally random inputs), advance the model, then compare.
  task automatic applyStimulus(input bit r, input bit rnd);
    int pos, d, c;
    logic [3:0] eAn;
    logic [6:0] eSeg;
    logic       eDp, eFd;
    @(negedge clk);
    rst = r;
    if (rnd && ($urandom_range(0, 7) == 0)) begin
      seg0 = 7'($urandom); seg1 = 7'($urandom);
      seg2 = 7'($urandom); seg3 = 7'($urandom);
      dp_in = 4'($urandom); digit_en = 4'($urandom);
    end
    @(posedge clk);
    if (r) t = 0;
    else begin
      t++;
      if ((t - 1) % FRAME == 0) begin
        mSeg[0] = seg0; mSeg[1] = seg1; mSeg[2] = seg2; mSeg[3] = seg3;
        mDp = dp_in; mEn = digit_en;
      end
    end
    #1;
    eAn = 4'hF; eSeg = 7'h7F; eDp = 1'b1; eFd = 1'b0;
    c = 0;
    if (t > 0) begin
      pos = (t - 1) % FRAME;
      d   = pos / CLK_DIV;
      c   = pos % CLK_DIV;
      eFd = (pos == FRAME - 1);
      if (c >= BLANK) begin
        eSeg = mSeg[d];
        eDp  = mDp[d];
        if (mEn[d]) eAn = 4'hF & ~(4'b0001 << d);
      end
    end
    checkOutput("an", 32'(an), 32'(eAn));
    checkOutput("seg", 32'(seg), 32'(eSeg));
    checkOutput("dp", 32'(dp), 32'(eDp));
    checkOutput("frame_done", 32'(frame_done), 32'(eFd));
    if (rnd) begin
      checkOutput("an_onehot", 32'($countones(~an) <= 1), 32'd1);
      if (c < BLANK) checkOutput("an_blank", 32'(an), 32'hF);
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    seg0 = 7'h40; seg1 = 7'h79; seg2 = 7'h24; seg3 = 7'h30;
    dp_in = 4'hF; digit_en = 4'hF;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

    // Basic frame with digits 0..3.
    runCycles(FRAME);

    // Mid-frame change of seg1 during digit 0's ON phase must wait for the next frame.
    runCycles(4);
    seg1 = 7'h19;
    runCycles(FRAME - 4 + FRAME);

    digit_en = 4'b0101;
    runCycles(2 * FRAME);
    digit_en = 4'hF;
    dp_in = 4'b1011;
    runCycles(2 * FRAME);
    dp_in = 4'hF;
    digit_en = 4'b0000;
    runCycles(2 * FRAME);
    digit_en = 4'hF;

    // Reset while showing digit 2, cnt=5, then release with a new enable mask.
    for (int i = 0; i < FRAME && ((t - 1) % FRAME) != 21; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("pre_reset_pos", 32'((t - 1) % FRAME), 32'd21);
    applyStimulus(1'b1, 1'b0);
    digit_en = 4'b1010;
    runCycles(2 * FRAME);

    // Random frames with occasional resets.
    for (int i = 0; i < 1000 * FRAME; i++)
      applyStimulus($urandom_range(0, 999) == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
